spi_boot_loader: RTL and testbench
==================================

SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

Interface
REQ-001 SHALL have parameter BOOT_START_ADDR, default 18'h0C000, first SRAM address written.
REQ-002 SHALL have parameter BOOT_END_ADDR, default 18'h0FFFF, last SRAM address written.
REQ-003 SHALL have parameter WE_CYCLES, default 4, ram_we_b low width in clk100 cycles.
REQ-004 clk100  input  1  sole clock, 100 MHz; every flop on its rising edge.
REQ-005 reset_b  input  1  asynchronous, active-low reset.
REQ-006 arm_ss  input  1  SPI slave select from ARM, active-low frame.
REQ-007 arm_sclk  input  1  SPI clock, up to 20 MHz, idles high.
REQ-008 arm_mosi  input  1  SPI data, MSB first, sampled on sclk rising edge.
REQ-009 booting  output  1  high while the loader owns SRAM and the CPU is held in reset.
REQ-010 ram_addr  output  18  SRAM address.
REQ-011 ram_dout  output  8  SRAM write data.
REQ-012 ram_cs_b, ram_we_b, ram_oe_b  output  1 each  active-low SRAM controls.
REQ-013 overflow  output  1  sticky flag: byte received beyond BOOT_END_ADDR.

Function
REQ-014 arm_ss, arm_sclk, arm_mosi SHALL each pass a 2-flop synchronizer; sclk rising edge detected with a third flop (detect latency 3 clk100 cycles).
REQ-015 States SHALL be IDLE, SHIFT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-016 IDLE -> SHIFT on synchronized ss low; bit counter and shift register cleared on entry.
REQ-017 In SHIFT, each detected sclk rising edge SHALL shift synchronized mosi into bit 0; 8th bit completes a byte.
REQ-018 On byte complete with address <= BOOT_END_ADDR: latch byte into ram_dout, go WR_SETUP; else drop byte, set overflow, stay SHIFT.
REQ-019 WR_SETUP (1 cycle): ram_cs_b low, ram_we_b high; WR_PULSE (WE_CYCLES cycles): ram_we_b low; WR_HOLD (1 cycle): ram_we_b high, cs low, addr/data stable; then address +1, back to SHIFT.
REQ-020 ram_addr and ram_dout SHALL be stable from WR_SETUP through WR_HOLD inclusive.
REQ-021 Shifting SHALL continue during WR_* states; a second byte completing before WR_HOLD ends SHALL set overflow and be dropped.
REQ-022 ram_oe_b SHALL be high whenever booting is high.
REQ-023 ss deasserting in SHIFT: partial byte discarded; if at least one byte written -> DONE, else -> IDLE.
REQ-024 ss deasserting during WR_*: write completes, then same rule as REQ-023.
REQ-025 DONE SHALL be terminal until reset: booting low, SRAM outputs high, SPI ignored.
REQ-026 Address SHALL never wrap; BOOT_END_ADDR is last written.

Reset
REQ-027 On reset_b low: state IDLE, booting 1, ram_addr BOOT_START_ADDR, ram_dout 0, ram_cs_b/ram_we_b/ram_oe_b 1, overflow 0, synchronizers to idle (ss 1, sclk 1).
REQ-028 Reset mid-write SHALL raise ram_we_b immediately (asynchronously); the interrupted byte is not guaranteed written.

Structure
REQ-029 State encoding and default BOOT_START_ADDR/BOOT_END_ADDR SHALL live in shared package atom_pkg.
REQ-030 Synchronizer+edge detect SHALL be sub-module spi_sync (one instance per SPI input; sclk edge output only on sclk).

Verification
REQ-031 Reset, ss low, send 8'hA5 at 20 MHz -> one WE pulse of 40 ns at 18'h0C000, data 8'hA5, CS low 60 ns.
REQ-032 Send 16384 bytes 0x00..0xFF repeating, raise ss -> SRAM 0xC000-0xFFFF matches, booting falls within 5 cycles of ss sync, overflow 0.
REQ-033 Send 16385 bytes -> byte 16385 not written, overflow 1, 0xFFFF holds byte 16384.
REQ-034 ss low, 5 bits, ss high -> no write, state IDLE, booting 1; next full frame writes 0xC000.
REQ-035 Assert reset_b during WR_PULSE -> ram_we_b high same cycle; after release ram_addr 0xC000, booting 1.
REQ-036 After DONE, toggle SPI with 4 bytes -> no SRAM activity, booting remains 0.

Source files
------------

// File: rtl/atom_pkg.sv
// Shared definitions for the SPI boot loader: FSM state encoding and default boot window.
package atom_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } boot_state_e;

  localparam logic [17:0] BOOT_START_DEF = 18'h0C000;
  localparam logic [17:0] BOOT_END_DEF   = 18'h0FFFF;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one SPI line, with an optional third flop for rising-edge detect.
module spi_sync #(
  parameter logic IDLE_VAL = 1'b1,
  parameter bit   EDGE_DET = 1'b0
) (
  input  logic clk100,
  input  logic reset_b,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk100 or negedge reset_b) begin
    if (!reset_b) begin
      s1_q <= IDLE_VAL;
      s2_q <= IDLE_VAL;
      s3_q <= IDLE_VAL;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign dout = s2_q;
  assign rise = EDGE_DET ? (s2_q & ~s3_q) : 1'b0;

endmodule

// File: rtl/spi_boot_loader.sv
// Receives a boot image over SPI and writes it byte-by-byte into SRAM while holding the CPU off.
module spi_boot_loader
  import atom_pkg::*;
#(
  parameter logic [17:0] BOOT_START_ADDR = BOOT_START_DEF,
  parameter logic [17:0] BOOT_END_ADDR   = BOOT_END_DEF,
  parameter int unsigned WE_CYCLES       = 4
) (
  input  logic        clk100,
  input  logic        reset_b,
  input  logic        arm_ss,
  input  logic        arm_sclk,
  input  logic        arm_mosi,
  output logic        booting,
  output logic [17:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_cs_b,
  output logic        ram_we_b,
  output logic        ram_oe_b,
  output logic        overflow
);

  localparam int unsigned CntW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  logic ss_s, sclk_s, mosi_s, sclk_rise;
  logic unused_ss_rise, unused_mosi_rise, unused_sclk_s;

  spi_sync #(.IDLE_VAL(1'b1), .EDGE_DET(1'b0)) u_sync_ss (
    .clk100 (clk100),
    .reset_b(reset_b),
    .din    (arm_ss),
    .dout   (ss_s),
    .rise   (unused_ss_rise)
  );

  spi_sync #(.IDLE_VAL(1'b1), .EDGE_DET(1'b1)) u_sync_sclk (
    .clk100 (clk100),
    .reset_b(reset_b),
    .din    (arm_sclk),
    .dout   (sclk_s),
    .rise   (sclk_rise)
  );

  spi_sync #(.IDLE_VAL(1'b0), .EDGE_DET(1'b0)) u_sync_mosi (
    .clk100 (clk100),
    .reset_b(reset_b),
    .din    (arm_mosi),
    .dout   (mosi_s),
    .rise   (unused_mosi_rise)
  );

  assign unused_sclk_s = sclk_s;

  boot_state_e     state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [17:0]     addr_q, addr_d;
  logic [7:0]      dout_q, dout_d;
  logic [CntW-1:0] we_cnt_q, we_cnt_d;
  logic            ovf_q, ovf_d;
  logic            wrote_q, wrote_d;
  logic            full_q, full_d;
  logic            ss_gone_q, ss_gone_d;

  logic       shifting, in_write, byte_done;
  logic [7:0] byte_val;

  always_ff @(posedge clk100 or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      addr_q    <= BOOT_START_ADDR;
      dout_q    <= '0;
      we_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      wrote_q   <= 1'b0;
      full_q    <= 1'b0;
      ss_gone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      we_cnt_q  <= we_cnt_d;
      ovf_q     <= ovf_d;
      wrote_q   <= wrote_d;
      full_q    <= full_d;
      ss_gone_q <= ss_gone_d;
    end
  end

  assign in_write = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);
  assign shifting = (state_q == StShift) || in_write;
  assign byte_val = {shreg_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    we_cnt_d  = we_cnt_q;
    ovf_d     = ovf_q;
    wrote_d   = wrote_q;
    full_d    = full_q;
    ss_gone_d = ss_gone_q;
    byte_done = 1'b0;

    // Shifting runs alongside the write states so back-to-back bytes are not lost to timing.
    if (shifting) begin
      if (ss_s) begin
        bit_cnt_d = '0;
      end else if (sclk_rise) begin
        shreg_d   = byte_val;
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
      end
    end

    if (in_write) begin
      if (byte_done) ovf_d = 1'b1;
      if (ss_s) ss_gone_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!ss_s) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          shreg_d   = '0;
          ss_gone_d = 1'b0;
        end
      end
      StShift: begin
        if (ss_s) begin
          state_d = wrote_q ? StDone : StIdle;
        end else if (byte_done) begin
          if (!full_q) begin
            dout_d  = byte_val;
            state_d = StWrSetup;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      StWrSetup: begin
        we_cnt_d = '0;
        state_d  = StWrPulse;
      end
      StWrPulse: begin
        if (we_cnt_q == CntW'(WE_CYCLES - 1)) begin
          state_d = StWrHold;
        end else begin
          we_cnt_d = we_cnt_q + 1'b1;
        end
      end
      StWrHold: begin
        wrote_d   = 1'b1;
        ss_gone_d = 1'b0;
        // Saturate at the last address instead of wrapping; full_q blocks further writes.
        if (addr_q == BOOT_END_ADDR) begin
          full_d = 1'b1;
        end else begin
          addr_d = addr_q + 18'd1;
        end
        state_d = (ss_gone_q || ss_s) ? StDone : StShift;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign booting  = (state_q != StDone);
  assign ram_addr = addr_q;
  assign ram_dout = dout_q;
  assign ram_cs_b = ~in_write;
  assign ram_we_b = (state_q != StWrPulse);
  assign ram_oe_b = 1'b1;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Randomized bench: SPI frames into the loader, SRAM writes checked by a scoreboard monitor.
module tb_spi_boot_loader;

  localparam logic [17:0] START = 18'h0C000;
  localparam logic [17:0] LAST  = 18'h0C00F;
  localparam int          CAP   = 16;
  localparam int          WE    = 4;

  logic        clk100 = 1'b0;
  logic        reset_b = 1'b0;
  logic        arm_ss = 1'b1;
  logic        arm_sclk = 1'b1;
  logic        arm_mosi = 1'b0;
  logic        booting;
  logic [17:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_cs_b, ram_we_b, ram_oe_b, overflow;

  spi_boot_loader #(
    .BOOT_START_ADDR(START),
    .BOOT_END_ADDR  (LAST),
    .WE_CYCLES      (WE)
  ) dut (
    .clk100  (clk100),
    .reset_b (reset_b),
    .arm_ss  (arm_ss),
    .arm_sclk(arm_sclk),
    .arm_mosi(arm_mosi),
    .booting (booting),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .ram_cs_b(ram_cs_b),
    .ram_we_b(ram_we_b),
    .ram_oe_b(ram_oe_b),
    .overflow(overflow)
  );

  always #5 clk100 = ~clk100;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem[int];
  int         checks = 0;
  int         errors = 0;

  // Reference model: bytes land at consecutive addresses until the window is full.
  int   model_wr;
  bit   model_done;
  bit   exp_ovf;
  logic [7:0] last_in_range;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: one SRAM write = one contiguous CS-low window.
  int          cs_len = 0, we_len = 0;
  logic [17:0] cap_addr;
  logic [7:0]  cap_data;
  bit          stable;

  always @(negedge clk100) begin
    if (!reset_b) begin
      cs_len = 0;
      we_len = 0;
    end else begin
      check("oe_high", 32'(ram_oe_b), 32'd1);
      if (!ram_cs_b) begin
        if (cs_len == 0) begin
          cap_addr = ram_addr;
          cap_data = ram_dout;
          stable   = 1'b1;
        end else if (ram_addr !== cap_addr || ram_dout !== cap_data) begin
          stable = 1'b0;
        end
        cs_len++;
        if (!ram_we_b) we_len++;
      end else if (cs_len != 0) begin
        wr_t e;
        check("cs_width", 32'(cs_len), 32'd6);
        check("we_width", 32'(we_len), 32'(WE));
        check("addr_data_stable", 32'(stable), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {14'd0, cap_addr}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {14'd0, cap_addr}, {14'd0, e.addr});
          check("wr_data", {24'd0, cap_data}, {24'd0, e.data});
        end
        mem[int'(cap_addr)] = cap_data;
        cs_len = 0;
        we_len = 0;
      end
    end
  end

  task automatic do_reset();
    reset_b = 1'b0;
    arm_ss = 1'b1;
    arm_sclk = 1'b1;
    exp_q.delete();
    mem.delete();
    model_wr = 0;
    model_done = 1'b0;
    exp_ovf = 1'b0;
    repeat (3) @(negedge clk100);
    reset_b = 1'b1;
    repeat (2) @(negedge clk100);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      arm_sclk = 1'b0;
      arm_mosi = b[i];
      #25;
      arm_sclk = 1'b1;
      #25;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (!model_done) begin
      if (model_wr < CAP) begin
        exp_q.push_back('{addr: START + 18'(model_wr), data: b});
        last_in_range = b;
        model_wr++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    spi_bits(b, 8);
  endtask

  task automatic start_frame();
    arm_ss = 1'b0;
    #100;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk100);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic end_frame();
    int n;
    drain();
    #100;
    arm_ss = 1'b1;
    n = 0;
    if (model_wr > 0) begin
      while (booting && n < 20) begin
        @(negedge clk100);
        n++;
      end
      model_done = 1'b1;
      check("booting_fall", 32'(booting), 32'd0);
      check("booting_latency", 32'(n <= 7), 32'd1);
    end else begin
      repeat (10) @(negedge clk100);
      check("booting_idle", 32'(booting), 32'd1);
    end
  endtask

  initial begin
    int n;
    do_reset();
    check("rst_booting", 32'(booting), 32'd1);
    check("rst_addr", {14'd0, ram_addr}, {14'd0, START});
    check("rst_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_cs", 32'(ram_cs_b), 32'd1);
    check("rst_we", 32'(ram_we_b), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Frame of 0xA5 then random bytes, then SPI traffic after DONE must be ignored.
    start_frame();
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    end_frame();
    check("ovf_clean", 32'(overflow), 32'(exp_ovf));
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    #100;
    arm_ss = 1'b1;
    repeat (20) @(negedge clk100);
    check("done_booting", 32'(booting), 32'd0);
    check("done_no_writes", 32'(exp_q.size()), 32'd0);

    // Partial byte is discarded; the next full frame starts at the first address.
    do_reset();
    start_frame();
    spi_bits(8'($urandom), 5);
    end_frame();
    check("partial_addr", {14'd0, ram_addr}, {14'd0, START});
    start_frame();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    end_frame();

    // One byte past the window: dropped, overflow set, last address keeps the 16th byte.
    do_reset();
    start_frame();
    for (int i = 0; i < CAP + 1; i++) send_byte(8'($urandom));
    end_frame();
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("last_byte", {24'd0, mem.exists(int'(LAST)) ? mem[int'(LAST)] : 8'hxx},
          {24'd0, last_in_range});
    check("no_wrap", 32'(mem.exists(int'(START + 18'(CAP)))), 32'd0);

    // Reset in the middle of the write pulse drops WE immediately.
    do_reset();
    start_frame();
    send_byte(8'($urandom));
    n = 0;
    while (ram_we_b && n < 100) begin
      @(negedge clk100);
      n++;
    end
    check("we_seen_low", 32'(ram_we_b), 32'd0);
    #2;
    reset_b = 1'b0;
    exp_q.delete();
    #1;
    check("rst_we_async", 32'(ram_we_b), 32'd1);
    repeat (2) @(negedge clk100);
    reset_b = 1'b1;
    repeat (2) @(negedge clk100);
    check("rst_mid_addr", {14'd0, ram_addr}, {14'd0, START});
    check("rst_mid_booting", 32'(booting), 32'd1);
    arm_ss = 1'b1;
    repeat (10) @(negedge clk100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
